// File: rtl/bus_dma_arbiter_if.sv
// CPU-side and memory-side bus signals of the DMA arbiter.
// The slave modport is the arbiter. The master modport is the CPU plus memory environment.
interface bus_dma_arbiter_if;
  logic [15:0] cpuAddress;
  logic [7:0]  cpuDataOut;
  logic        cpuWriteEnable;
  logic [7:0]  cpuDataIn;
  logic [15:0] memAddress;
  logic [7:0]  memDataOut;
  logic        memWriteEnable;
  logic [7:0]  memDataIn;
  logic        dmaActive;

  modport slave (
    input  cpuAddress, cpuDataOut, cpuWriteEnable, memDataIn,
    output cpuDataIn, memAddress, memDataOut, memWriteEnable, dmaActive
  );

  modport master (
    output cpuAddress, cpuDataOut, cpuWriteEnable, memDataIn,
    input  cpuDataIn, memAddress, memDataOut, memWriteEnable, dmaActive
  );
endinterface

// File: rtl/bus_dma_arbiter.sv
// Bus controller: internal HRAM, OAM DMA register FF46, and memory-port arbitration.
// state | meaning
// IDLE  | CPU owns the memory port
// START | one idle port cycle, idx cleared
// READ  | source byte addressed
// WRITE | byte written to OAM, idx advances
module bus_dma_arbiter #(
  parameter int          DMA_LEN  = 160,
  parameter logic [15:0] OAM_BASE = 16'hFE00
) (
  input logic             clk,
  input logic             reset,
  bus_dma_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_WRITE} state_t;
  typedef enum logic [1:0] {SEL_MEM, SEL_HRAM, SEL_REG, SEL_BLOCKED} sel_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t     state_q, state_d;
  sel_t       sel_q, sel_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] dma_src_q, dma_src_d;
  logic [7:0] hram_rd_q, hram_rd_d;
  logic       dma_active_q, dma_active_d;
  logic [7:0] hram_q [0:126];

  logic       is_hram, is_reg, is_mem, dma_wr;
  logic [7:0] src_page;

  assign is_hram  = (bus.cpuAddress[15:7] == 9'h1FF) && (bus.cpuAddress[6:0] != 7'h7F);
  assign is_reg   = (bus.cpuAddress == 16'hFF46);
  assign is_mem   = !is_hram && !is_reg;
  assign dma_wr   = bus.cpuWriteEnable && is_reg;
  // Echo RAM E000-FDFF mirrors C000-DDFF.
  assign src_page = (dma_src_q >= 8'hE0) ? (dma_src_q - 8'h20) : dma_src_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dma_src_d = dma_src_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_START: begin
        idx_d   = 8'h00;
        state_d = S_READ;
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'h00;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A register write restarts the engine from any state, abandoning a partial copy.
    if (dma_wr) begin
      dma_src_d = bus.cpuDataOut;
      idx_d     = 8'h00;
      state_d   = S_START;
    end
    dma_active_d = (state_d != S_IDLE);

    if (is_hram)           sel_d = SEL_HRAM;
    else if (is_reg)       sel_d = SEL_REG;
    else if (dma_active_q) sel_d = SEL_BLOCKED;
    else                   sel_d = SEL_MEM;

    hram_rd_d = is_hram ? hram_q[bus.cpuAddress[6:0]] : hram_rd_q;
  end

  always_comb begin
    bus.memAddress     = bus.cpuAddress;
    bus.memDataOut     = bus.cpuDataOut;
    bus.memWriteEnable = 1'b0;
    case (state_q)
      S_IDLE:  bus.memWriteEnable = bus.cpuWriteEnable && is_mem;
      S_READ:  bus.memAddress = {src_page, idx_q};
      S_WRITE: begin
        bus.memAddress     = OAM_BASE + {8'h00, idx_q};
        bus.memDataOut     = bus.memDataIn;
        bus.memWriteEnable = 1'b1;
      end
      default: bus.memWriteEnable = 1'b0;
    endcase
  end

  always_comb begin
    case (sel_q)
      SEL_MEM:  bus.cpuDataIn = bus.memDataIn;
      SEL_HRAM: bus.cpuDataIn = hram_rd_q;
      SEL_REG:  bus.cpuDataIn = dma_src_q;
      default:  bus.cpuDataIn = 8'hFF;
    endcase
  end

  assign bus.dmaActive = dma_active_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sel_q        <= SEL_REG;
      idx_q        <= 8'h00;
      dma_src_q    <= 8'h00;
      hram_rd_q    <= 8'h00;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      idx_q        <= idx_d;
      dma_src_q    <= dma_src_d;
      hram_rd_q    <= hram_rd_d;
      dma_active_q <= dma_active_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.cpuWriteEnable && is_hram) hram_q[bus.cpuAddress[6:0]] <= bus.cpuDataOut;
  end

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Directed and randomized bench for bus_dma_arbiter with a registered-read memory model.
module tb_bus_dma_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bus_dma_arbiter_if bus ();
  bus_dma_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] mem [0:65535] = '{default: 8'h00};
  int wcount = 0;
  always @(posedge clk) begin
    if (bus.memWriteEnable === 1'b1) begin
      mem[bus.memAddress] <= bus.memDataOut;
      wcount <= wcount + 1;
    end
    bus.memDataIn <= mem[bus.memAddress];
  end

  int errors = 0;
  int checks = 0;
  int act_cnt = 0;
  logic [7:0] c1_dat [160];
  logic [7:0] c2_dat [160];
  logic [7:0] hram_ref [127];
  logic [6:0] hram_used [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] a, input logic we, input logic [7:0] d);
    bus.cpuAddress     = a;
    bus.cpuWriteEnable = we;
    bus.cpuDataOut     = d;
    @(posedge clk);
    #1;
    if (bus.dmaActive === 1'b1) act_cnt++;
  endtask

  task automatic hram_wr();
    logic [6:0] a;
    logic [7:0] d;
    a = 7'($urandom_range(0, 126));
    d = 8'($urandom);
    step({9'h1FF, a}, 1'b1, d);
    hram_ref[a] = d;
    hram_used.push_back(a);
  endtask

  task automatic hram_rd_chk(input string tag);
    logic [6:0] a;
    a = hram_used[$urandom_range(0, hram_used.size() - 1)];
    step({9'h1FF, a}, 1'b0, 8'h00);
    chk(tag, 32'(bus.cpuDataIn), 32'(hram_ref[a]));
  endtask

  task automatic run_to_idle(input string tag);
    int n = 0;
    while (bus.dmaActive === 1'b1 && n < 400) begin
      step(16'h0000, 1'b0, 8'h00);
      n++;
    end
    chk({tag, "_ends"}, 32'(bus.dmaActive), 'h0);
  endtask

  task automatic wait_writes(input string tag, input int base, input int n);
    int k = 0;
    while ((wcount - base) < n && k < 400) begin
      step(16'h0000, 1'b0, 8'h00);
      k++;
    end
    chk({tag, "_write_count"}, 32'(wcount - base), 32'(n));
  endtask

  task automatic chk_oam(input string tag, input logic [7:0] e [160]);
    for (int i = 0; i < 160; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(mem[16'hFE00 + 16'(i)]), 32'(e[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, n;
    bus.cpuAddress = 16'h0000;
    bus.cpuWriteEnable = 1'b0;
    bus.cpuDataOut = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dmaActive", 32'(bus.dmaActive), 'h0);
    chk("rst_cpuDataIn", 32'(bus.cpuDataIn), 'h00);
    chk("rst_memWriteEnable", 32'(bus.memWriteEnable), 'h0);
    @(negedge clk);
    reset = 1'b1;

    w0 = wcount;
    step(16'hFF90, 1'b1, 8'h5A);
    hram_ref[7'h10] = 8'h5A;
    hram_used.push_back(7'h10);
    step(16'hFF90, 1'b0, 8'h00);
    chk("hram_ff90", 32'(bus.cpuDataIn), 'h5A);
    chk("hram_no_mem_write", 32'(wcount - w0), 'h0);
    repeat (6) hram_wr();
    repeat (6) hram_rd_chk("hram_idle");

    for (int i = 0; i < 160; i++) begin
      c1_dat[i] = 8'(i) ^ 8'hA5;
      c2_dat[i] = 8'($urandom);
      step(16'hC100 + 16'(i), 1'b1, c1_dat[i]);
      step(16'hC200 + 16'(i), 1'b1, c2_dat[i]);
    end
    step(16'h1000, 1'b1, 8'h3C);
    step(16'hC105, 1'b0, 8'h00);
    chk("mem_read_c105", 32'(bus.cpuDataIn), 'hA0);

    // full copy from C1 with CPU traffic during the transfer
    w0 = wcount;
    act_cnt = 0;
    step(16'hFF46, 1'b1, 8'hC1);
    chk("c1_active_rises", 32'(bus.dmaActive), 'h1);
    n = 0;
    while (bus.dmaActive === 1'b1 && n < 400) begin
      if (n == 10) step(16'h1000, 1'b1, 8'h77);
      else if (n == 11) begin
        step(16'h1000, 1'b0, 8'h00);
        chk("blocked_read", 32'(bus.cpuDataIn), 'hFF);
      end
      else if (n % 8 == 3) hram_wr();
      else if (n % 8 == 6) hram_rd_chk("hram_dma");
      else step(16'h0000, 1'b0, 8'h00);
      n++;
    end
    chk("c1_active_cycles", 32'(act_cnt), 'd321);
    chk("c1_mem_writes", 32'(wcount - w0), 'd160);
    chk("blocked_write", 32'(mem[16'h1000]), 'h3C);
    chk_oam("c1_oam", c1_dat);
    step(16'hFF46, 1'b0, 8'h00);
    chk("ff46_read_c1", 32'(bus.cpuDataIn), 'hC1);
    step(16'h1000, 1'b0, 8'h00);
    chk("unblocked_read", 32'(bus.cpuDataIn), 'h3C);

    // restart after 50 bytes with page C2
    w0 = wcount;
    step(16'hFF46, 1'b1, 8'hC1);
    wait_writes("restart", w0, 50);
    w1 = wcount;
    act_cnt = 0;
    step(16'hFF46, 1'b1, 8'hC2);
    run_to_idle("restart");
    chk("restart_active_cycles", 32'(act_cnt), 'd321);
    chk("restart_mem_writes", 32'(wcount - w1), 'd160);
    chk_oam("c2_oam", c2_dat);

    // echo page E1 sources C100
    act_cnt = 0;
    step(16'hFF46, 1'b1, 8'hE1);
    run_to_idle("echo");
    chk("echo_active_cycles", 32'(act_cnt), 'd321);
    chk_oam("echo_oam", c1_dat);
    step(16'hFF46, 1'b0, 8'h00);
    chk("ff46_read_e1", 32'(bus.cpuDataIn), 'hE1);

    // register write coinciding with the final byte write
    w0 = wcount;
    step(16'hFF46, 1'b1, 8'hC2);
    wait_writes("last", w0, 159);
    step(16'h0000, 1'b0, 8'h00);
    act_cnt = 0;
    step(16'hFF46, 1'b1, 8'hC1);
    chk("last_byte_written", 32'(wcount - w0), 'd160);
    chk("last_byte_value", 32'(mem[16'hFE9F]), 32'(c2_dat[159]));
    chk("last_restart_active", 32'(bus.dmaActive), 'h1);
    run_to_idle("last");
    chk("last_active_cycles", 32'(act_cnt), 'd321);
    chk_oam("last_oam", c1_dat);

    // reset asserted after 80 bytes of a C2 copy
    w0 = wcount;
    step(16'hFF46, 1'b1, 8'hC2);
    wait_writes("rstmid", w0, 80);
    reset = 1'b0;
    #1;
    chk("rstmid_async_active", 32'(bus.dmaActive), 'h0);
    chk("rstmid_memwe", 32'(bus.memWriteEnable), 'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    w1 = wcount;
    repeat (20) step(16'h0000, 1'b0, 8'h00);
    chk("rstmid_no_writes_after", 32'(wcount - w1), 'h0);
    chk("rstmid_total_writes", 32'(w1 - w0), 'd80);
    for (int i = 0; i < 160; i++)
      chk($sformatf("rstmid_oam[%0d]", i), 32'(mem[16'hFE00 + 16'(i)]),
          32'((i < 80) ? c2_dat[i] : c1_dat[i]));
    step(16'hFF46, 1'b0, 8'h00);
    chk("rstmid_ff46_cleared", 32'(bus.cpuDataIn), 'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_dma_arbiter.md
# bus_dma_arbiter

Bus controller between the `CPU` bus port (`address`, `dataOut`, `dataIn`, `busWriteEnable`) and the single-port system memory. It owns high RAM (FF80–FFFE) internally, implements the DMG OAM DMA register FF46, and arbitrates the memory port between the CPU and the DMA engine. During a DMA transfer it blocks CPU access to everything except HRAM and FF46.

## Interface
- `DMA_LEN`, 160: bytes copied per transfer.
- `OAM_BASE`, 16'hFE00: DMA destination base.
- `clk` input 1: system clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cpuAddress` input 16: CPU bus address, valid every cycle.
- `cpuDataOut` input 8: CPU write data.
- `cpuWriteEnable` input 1: 1 = CPU write this cycle.
- `cpuDataIn` output 8: read data for the address presented one cycle earlier.
- `memAddress` output 16: memory port address (combinational).
- `memDataOut` output 8: memory write data (combinational).
- `memWriteEnable` output 1: memory write strobe (combinational).
- `memDataIn` input 8: memory read data, registered by memory, one-cycle latency.
- `dmaActive` output 1: registered; high while a transfer is pending or running.

## Operation
- Address classes: HRAM = FF80–FFFE; DMAREG = FF46; MEM = all other addresses.
- HRAM is a 127×8 internal array. Writes land on the clock edge. Reads are registered with 1-cycle latency. HRAM accesses never reach the memory port.
- FF46 write latches `dmaSrc` and starts a transfer. The write is not forwarded to memory. A read of FF46 returns `dmaSrc`.
- Source address = {page, idx}. If the page is ≥ E0, use page − 20 (echo RAM maps to C0–DF).
- State machine:
  - IDLE: CPU owns the memory port. MEM accesses pass through combinationally: `memAddress=cpuAddress`, `memDataOut=cpuDataOut`, `memWriteEnable=cpuWriteEnable && class==MEM`.
  - START: one cycle. Set idx=0. Memory port idle (`memWriteEnable=0`, `memAddress=cpuAddress`).
  - READ: `memAddress`=source address, `memWriteEnable=0`.
  - WRITE: `memAddress=OAM_BASE+idx`, `memDataOut=memDataIn`, `memWriteEnable=1`. Then increment idx. If idx was `DMA_LEN`−1, go to IDLE; otherwise go to READ.
- A FF46 write in any state goes to START with the new page and idx=0. A partial transfer is abandoned.
- While `dmaActive` is high, CPU MEM accesses are blocked: writes are dropped, and the read returns FF. HRAM and FF46 accesses stay fully functional.
- `cpuDataIn` comes from a registered source select (MEM/HRAM/REG/BLOCKED) captured with each address:
  - MEM → `memDataIn`
  - HRAM → registered HRAM data
  - REG → registered `dmaSrc`
  - BLOCKED → FF
- idx is 8 bits and never exceeds `DMA_LEN`−1.

## Timing
- Reset values: state IDLE, `dmaActive`=0, `dmaSrc`=00, idx=0, `cpuDataIn`=00 (select = REG with `dmaSrc`=00). HRAM contents are not reset.
- Reset asserted mid-transfer: the transfer is aborted immediately and the block is in IDLE on release. No further memory writes occur.
- Edge E0 captures the FF46 write, then START.
- E1 → READ idx 0. E2 → WRITE. E3 → byte 0 written.
- Byte i is written at edge E3+2i. The last byte is written at E3+318.
- `dmaActive` rises after E0 and falls after E3+318: 321 cycles high in total.
- The block adds no CPU-side wait states. Read latency is 1 cycle for every address class.
- FF46 write on the same edge as the final WRITE: the final byte is still written, then START.

## Test plan
- Reset, then the CPU writes 5A to FF90 and reads FF90 → `cpuDataIn`=5A one cycle after the read address. External memory sees no write.
- Preload C100–C19F with i^A5 and the CPU writes C1 to FF46 → FE00+i = i^A5 for all 160 bytes. `dmaActive` is high for exactly 321 cycles. A read of FF46 returns C1.
- During DMA, the CPU writes 77 to 1000 and reads 1000 → memory[1000] is unchanged and the read returns FF. The CPU executing reads/writes in FF80–FFFE works normally throughout.
- Write E1 to FF46 with C100 preloaded → the copy sources C100 (echo remap).
- Mid-transfer (after 50 bytes) write C2 to FF46 → the transfer restarts at idx 0 from C200. FE00–FE9F end equal to C200–C29F. `dmaActive` stays high 321 cycles after the second write.
- Assert `reset` low at byte 80 → `dmaActive`=0 asynchronously. FE50–FE9F are untouched, and no memory write occurs after release until a new FF46 write.
